// File: rtl/ivport_fire_sched_if.sv
// Egress fire interface between ivport queues, the fire scheduler and the egress PHY.
// slave = scheduler view, master = ivport/egress view.
interface ivport_fire_sched_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  rreq_empty;
  logic                  rresp_empty;
  logic                  wreq_empty;
  logic                  fire_halt;
  logic                  fire_en;
  logic [1:0]            fire_type_sel;
  logic [DATA_WIDTH-1:0] fire_ipg_data;
  logic                  tx_ipg_slot;
  logic                  tx_ipg_valid;
  logic [DATA_WIDTH-1:0] tx_ipg_data;
  logic [1:0]            tx_ipg_type;

  modport slave (
    input  rreq_empty, rresp_empty, wreq_empty, fire_halt, fire_ipg_data, tx_ipg_slot,
    output fire_en, fire_type_sel, tx_ipg_valid, tx_ipg_data, tx_ipg_type
  );

  modport master (
    output rreq_empty, rresp_empty, wreq_empty, fire_halt, fire_ipg_data, tx_ipg_slot,
    input  fire_en, fire_type_sel, tx_ipg_valid, tx_ipg_data, tx_ipg_type
  );
endinterface

// File: rtl/ivport_fire_sched.sv
// Egress fire scheduler: priority/aging pick among RREQ/RRESP/WREQ queues into a one-entry output register.
// Optional pop statistics counters are enabled with the IVPORT_FIRE_STATS_EN macro.
//
// state     | meaning
// ST_IDLE   | output register empty
// ST_LOADED | output register holds a word awaiting an IPG slot
module ivport_fire_sched #(
  parameter int DATA_WIDTH   = 64,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef IVPORT_FIRE_STATS_EN
  input  logic                 stat_clr,
  output logic [CNT_WIDTH-1:0] stat_rreq,
  output logic [CNT_WIDTH-1:0] stat_rresp,
  output logic [CNT_WIDTH-1:0] stat_wreq,
`endif
  ivport_fire_sched_if.slave   fif
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOADED = 1'b1;

  localparam logic [1:0] SEL_RREQ  = 2'd0;
  localparam logic [1:0] SEL_RRESP = 2'd1;
  localparam logic [1:0] SEL_WREQ  = 2'd2;
  localparam logic [1:0] SEL_NONE  = 2'd3;

  localparam int               AGE_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

  logic [0:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [1:0]            type_q, type_d;
  logic [AGE_W-1:0]      rreq_age_q, rreq_age_d;
  logic [AGE_W-1:0]      wreq_age_q, wreq_age_d;

  logic       valid;
  logic       consume;
  logic       any_ne;
  logic       can_pop;
  logic [1:0] sel;

  assign valid   = (state_q == ST_LOADED);
  assign consume = valid & fif.tx_ipg_slot;
  assign any_ne  = ~fif.rreq_empty | ~fif.rresp_empty | ~fif.wreq_empty;
  // Reset gates the pop strobe combinationally so nothing is drained from ivport while held in reset.
  assign can_pop = rst & (~valid | consume) & ~fif.fire_halt & any_ne;

  always_comb begin
    sel = SEL_NONE;
    if (!fif.wreq_empty && (wreq_age_q >= AGE_MAX))      sel = SEL_WREQ;
    else if (!fif.rreq_empty && (rreq_age_q >= AGE_MAX)) sel = SEL_RREQ;
    else if (!fif.rresp_empty)                           sel = SEL_RRESP;
    else if (!fif.rreq_empty)                            sel = SEL_RREQ;
    else if (!fif.wreq_empty)                            sel = SEL_WREQ;
  end

  assign fif.fire_en       = can_pop;
  assign fif.fire_type_sel = can_pop ? sel : SEL_NONE;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    type_d  = type_q;
    if (can_pop) begin
      state_d = ST_LOADED;
      data_d  = fif.fire_ipg_data;
      type_d  = sel;
    end else if (consume) begin
      state_d = ST_IDLE;
    end
  end

  // Empty wins over hold: a queue seen empty has nothing waiting, so its age restarts.
  always_comb begin
    rreq_age_d = rreq_age_q;
    if (fif.rreq_empty || (can_pop && sel == SEL_RREQ)) rreq_age_d = '0;
    else if (can_pop && rreq_age_q < AGE_MAX)           rreq_age_d = rreq_age_q + 1'b1;

    wreq_age_d = wreq_age_q;
    if (fif.wreq_empty || (can_pop && sel == SEL_WREQ)) wreq_age_d = '0;
    else if (can_pop && wreq_age_q < AGE_MAX)           wreq_age_d = wreq_age_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      type_q     <= SEL_NONE;
      rreq_age_q <= '0;
      wreq_age_q <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      type_q     <= type_d;
      rreq_age_q <= rreq_age_d;
      wreq_age_q <= wreq_age_d;
    end
  end

  assign fif.tx_ipg_valid = valid;
  assign fif.tx_ipg_data  = data_q;
  assign fif.tx_ipg_type  = type_q;

`ifdef IVPORT_FIRE_STATS_EN
  logic [CNT_WIDTH-1:0] stat_rreq_q, stat_rreq_d;
  logic [CNT_WIDTH-1:0] stat_rresp_q, stat_rresp_d;
  logic [CNT_WIDTH-1:0] stat_wreq_q, stat_wreq_d;

  always_comb begin
    stat_rreq_d  = stat_rreq_q;
    stat_rresp_d = stat_rresp_q;
    stat_wreq_d  = stat_wreq_q;
    if (stat_clr) begin
      stat_rreq_d  = '0;
      stat_rresp_d = '0;
      stat_wreq_d  = '0;
    end else if (can_pop) begin
      if (sel == SEL_RREQ && stat_rreq_q != '1)   stat_rreq_d  = stat_rreq_q + 1'b1;
      if (sel == SEL_RRESP && stat_rresp_q != '1) stat_rresp_d = stat_rresp_q + 1'b1;
      if (sel == SEL_WREQ && stat_wreq_q != '1)   stat_wreq_d  = stat_wreq_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_rreq_q  <= '0;
      stat_rresp_q <= '0;
      stat_wreq_q  <= '0;
    end else begin
      stat_rreq_q  <= stat_rreq_d;
      stat_rresp_q <= stat_rresp_d;
      stat_wreq_q  <= stat_wreq_d;
    end
  end

  assign stat_rreq  = stat_rreq_q;
  assign stat_rresp = stat_rresp_q;
  assign stat_wreq  = stat_wreq_q;
`endif

endmodule

// File: tb/tb_ivport_fire_sched.sv
// Bench for ivport_fire_sched: directed vector table plus queue-model sequences.
// Stats checks are compiled in when IVPORT_FIRE_STATS_EN is defined.
module tb_ivport_fire_sched;
  localparam int DW = 64;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ivport_fire_sched_if #(.DATA_WIDTH(DW)) ifc ();

`ifdef IVPORT_FIRE_STATS_EN
  logic          stat_clr;
  logic [CW-1:0] stat_rreq, stat_rresp, stat_wreq;
`endif

  ivport_fire_sched #(.DATA_WIDTH(DW), .STARVE_LIMIT(4), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef IVPORT_FIRE_STATS_EN
    .stat_clr   (stat_clr),
    .stat_rreq  (stat_rreq),
    .stat_rresp (stat_rresp),
    .stat_wreq  (stat_wreq),
`endif
    .fif        (ifc.slave)
  );

  logic [DW-1:0] head_rreq, head_rresp, head_wreq;
  assign ifc.fire_ipg_data = (ifc.fire_type_sel == 2'd0) ? head_rreq  :
                             (ifc.fire_type_sel == 2'd1) ? head_rresp :
                             (ifc.fire_type_sel == 2'd2) ? head_wreq  : '0;

  logic [DW-1:0] q_rreq[$], q_rresp[$], q_wreq[$];
  bit use_model;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic refresh();
    ifc.rreq_empty  = (q_rreq.size() == 0);
    ifc.rresp_empty = (q_rresp.size() == 0);
    ifc.wreq_empty  = (q_wreq.size() == 0);
    head_rreq  = (q_rreq.size() != 0)  ? q_rreq[0]  : '0;
    head_rresp = (q_rresp.size() != 0) ? q_rresp[0] : '0;
    head_wreq  = (q_wreq.size() != 0)  ? q_wreq[0]  : '0;
  endtask

  // One clock: the model pops whatever the DUT strobed just before the edge.
  task automatic tick();
    logic       pop_now;
    logic [1:0] sel_now;
    pop_now = ifc.fire_en;
    sel_now = ifc.fire_type_sel;
    @(posedge clk);
    #1;
    if (use_model) begin
      if (pop_now) begin
        case (sel_now)
          2'd0: if (q_rreq.size() != 0)  void'(q_rreq.pop_front());
          2'd1: if (q_rresp.size() != 0) void'(q_rresp.pop_front());
          2'd2: if (q_wreq.size() != 0)  void'(q_wreq.pop_front());
          default: ;
        endcase
      end
      refresh();
    end
    #1;
  endtask

  typedef struct {
    logic          rst;
    logic [2:0]    emp;   // {rreq, rresp, wreq} empty flags
    logic          halt;
    logic          slot;
    logic [DW-1:0] data;
    logic          en;
    logic [1:0]    sel;
    logic          valid;
    logic [1:0]    typ;
    logic [DW-1:0] tdata;
    logic          chk_word;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [DW-1:0] word_x, word_y, exp_d;
    logic [1:0]    exp_t[7];
    int            pushed, popped;

    rst = 1'b0;
    ifc.fire_halt   = 1'b0;
    ifc.tx_ipg_slot = 1'b1;
    ifc.rreq_empty  = 1'b1;
    ifc.rresp_empty = 1'b1;
    ifc.wreq_empty  = 1'b1;
    head_rreq = '0; head_rresp = '0; head_wreq = '0;
    use_model = 1'b0;
`ifdef IVPORT_FIRE_STATS_EN
    stat_clr = 1'b0;
`endif

    //              rst emp     hlt slt data    en sel  v  typ tdata   chk
    tbl[0]  = '{1'b0, 3'b000, 1'b0, 1'b1, 64'h11, 1'b0, 2'd3, 1'b0, 2'd3, 64'h0,  1'b1};
    tbl[1]  = '{1'b1, 3'b111, 1'b0, 1'b1, 64'h12, 1'b0, 2'd3, 1'b0, 2'd3, 64'h0,  1'b1};
    tbl[2]  = '{1'b1, 3'b011, 1'b0, 1'b1, 64'hA1, 1'b1, 2'd0, 1'b1, 2'd0, 64'hA1, 1'b1};
    tbl[3]  = '{1'b1, 3'b110, 1'b0, 1'b0, 64'hB3, 1'b0, 2'd3, 1'b1, 2'd0, 64'hA1, 1'b1};
    tbl[4]  = '{1'b1, 3'b000, 1'b0, 1'b0, 64'hB4, 1'b0, 2'd3, 1'b1, 2'd0, 64'hA1, 1'b1};
    tbl[5]  = '{1'b1, 3'b000, 1'b0, 1'b1, 64'hC5, 1'b1, 2'd1, 1'b1, 2'd1, 64'hC5, 1'b1};
    tbl[6]  = '{1'b1, 3'b000, 1'b1, 1'b1, 64'hC6, 1'b0, 2'd3, 1'b0, 2'd1, 64'hC5, 1'b0};
    tbl[7]  = '{1'b1, 3'b010, 1'b0, 1'b0, 64'hD7, 1'b1, 2'd0, 1'b1, 2'd0, 64'hD7, 1'b1};
    tbl[8]  = '{1'b1, 3'b100, 1'b0, 1'b1, 64'hE8, 1'b1, 2'd1, 1'b1, 2'd1, 64'hE8, 1'b1};
    tbl[9]  = '{1'b1, 3'b100, 1'b0, 1'b1, 64'hE9, 1'b1, 2'd1, 1'b1, 2'd1, 64'hE9, 1'b1};
    tbl[10] = '{1'b1, 3'b100, 1'b0, 1'b1, 64'hEA, 1'b1, 2'd2, 1'b1, 2'd2, 64'hEA, 1'b1};
    tbl[11] = '{1'b0, 3'b000, 1'b0, 1'b1, 64'hEB, 1'b0, 2'd3, 1'b0, 2'd3, 64'h0,  1'b1};

    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].rst;
      ifc.rreq_empty  = tbl[i].emp[2];
      ifc.rresp_empty = tbl[i].emp[1];
      ifc.wreq_empty  = tbl[i].emp[0];
      ifc.fire_halt   = tbl[i].halt;
      ifc.tx_ipg_slot = tbl[i].slot;
      head_rreq = tbl[i].data; head_rresp = tbl[i].data; head_wreq = tbl[i].data;
      #1;
      chk($sformatf("vec%0d fire_en", i), DW'(ifc.fire_en), DW'(tbl[i].en));
      chk($sformatf("vec%0d fire_type_sel", i), DW'(ifc.fire_type_sel), DW'(tbl[i].sel));
      tick();
      chk($sformatf("vec%0d tx_ipg_valid", i), DW'(ifc.tx_ipg_valid), DW'(tbl[i].valid));
      if (tbl[i].chk_word) begin
        chk($sformatf("vec%0d tx_ipg_type", i), DW'(ifc.tx_ipg_type), DW'(tbl[i].typ));
        chk($sformatf("vec%0d tx_ipg_data", i), ifc.tx_ipg_data, tbl[i].tdata);
      end
    end

    // Reset held with all queues loaded
    use_model = 1'b1;
    rst = 1'b0;
    ifc.fire_halt = 1'b0;
    ifc.tx_ipg_slot = 1'b1;
    q_rreq.push_back(64'hA1);
    q_rresp.push_back(64'hB1);
    q_rresp.push_back(64'hB2);
    q_wreq.push_back(64'hC1);
    refresh();
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst fire_en", DW'(ifc.fire_en), DW'(0));
      chk("rst fire_type_sel", DW'(ifc.fire_type_sel), DW'(3));
      tick();
      chk("rst tx_ipg_valid", DW'(ifc.tx_ipg_valid), DW'(0));
      chk("rst tx_ipg_type", DW'(ifc.tx_ipg_type), DW'(3));
    end

    // Priority order
    rst = 1'b1;
    #1;
    exp_t[0] = 2'd1; exp_t[1] = 2'd1; exp_t[2] = 2'd0; exp_t[3] = 2'd2;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_d = (i == 0) ? 64'hB1 : (i == 1) ? 64'hB2 : (i == 2) ? 64'hA1 : 64'hC1;
      chk($sformatf("prio%0d valid", i), DW'(ifc.tx_ipg_valid), DW'(1));
      chk($sformatf("prio%0d type", i), DW'(ifc.tx_ipg_type), DW'(exp_t[i]));
      chk($sformatf("prio%0d data", i), ifc.tx_ipg_data, exp_d);
    end
    tick();
    chk("prio drain valid", DW'(ifc.tx_ipg_valid), DW'(0));

    // Backpressure
    word_x = 64'h008056781234561a;
    word_y = 64'h00000000cafe0002;
    ifc.tx_ipg_slot = 1'b0;
    q_rreq.push_back(word_x);
    q_wreq.push_back(word_y);
    refresh();
    #1;
    chk("bp first fire_en", DW'(ifc.fire_en), DW'(1));
    chk("bp first sel", DW'(ifc.fire_type_sel), DW'(0));
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d fire_en", i), DW'(ifc.fire_en), DW'(0));
      tick();
      chk($sformatf("bp%0d valid", i), DW'(ifc.tx_ipg_valid), DW'(1));
      chk($sformatf("bp%0d data", i), ifc.tx_ipg_data, word_x);
      chk($sformatf("bp%0d type", i), DW'(ifc.tx_ipg_type), DW'(0));
    end
    ifc.tx_ipg_slot = 1'b1;
    #1;
    chk("bp release fire_en", DW'(ifc.fire_en), DW'(1));
    chk("bp release sel", DW'(ifc.fire_type_sel), DW'(2));
    tick();
    chk("bp next valid", DW'(ifc.tx_ipg_valid), DW'(1));
    chk("bp next data", ifc.tx_ipg_data, word_y);
    chk("bp next type", DW'(ifc.tx_ipg_type), DW'(2));
    tick();
    chk("bp drain valid", DW'(ifc.tx_ipg_valid), DW'(0));

    // Starvation with RRESP refilled every cycle
    pushed = 0;
    popped = 0;
    q_wreq.push_back(64'hD1);
    exp_t[0] = 2'd1; exp_t[1] = 2'd1; exp_t[2] = 2'd1; exp_t[3] = 2'd1;
    exp_t[4] = 2'd2; exp_t[5] = 2'd1; exp_t[6] = 2'd1;
    for (int i = 0; i < 7; i++) begin
      if (q_rresp.size() == 0) begin
        q_rresp.push_back(64'h5000 + DW'(pushed));
        pushed++;
      end
      refresh();
      #1;
      tick();
      chk($sformatf("starve%0d type", i), DW'(ifc.tx_ipg_type), DW'(exp_t[i]));
      if (exp_t[i] == 2'd1) begin
        chk($sformatf("starve%0d data", i), ifc.tx_ipg_data, 64'h5000 + DW'(popped));
        popped++;
      end else begin
        chk($sformatf("starve%0d data", i), ifc.tx_ipg_data, 64'hD1);
      end
    end
    tick();
    chk("starve drain valid", DW'(ifc.tx_ipg_valid), DW'(0));

    // Halt while a word is held
    ifc.tx_ipg_slot = 1'b0;
    q_rreq.push_back(64'hF1);
    q_rreq.push_back(64'hF2);
    refresh();
    #1;
    tick();
    chk("halt held data", ifc.tx_ipg_data, 64'hF1);
    ifc.fire_halt = 1'b1;
    ifc.tx_ipg_slot = 1'b1;
    #1;
    chk("halt fire_en", DW'(ifc.fire_en), DW'(0));
    chk("halt sel", DW'(ifc.fire_type_sel), DW'(3));
    tick();
    chk("halt drained valid", DW'(ifc.tx_ipg_valid), DW'(0));
    chk("halt idle fire_en", DW'(ifc.fire_en), DW'(0));
    tick();
    chk("halt idle valid", DW'(ifc.tx_ipg_valid), DW'(0));
    ifc.fire_halt = 1'b0;
    #1;
    chk("unhalt fire_en", DW'(ifc.fire_en), DW'(1));
    tick();
    chk("unhalt valid", DW'(ifc.tx_ipg_valid), DW'(1));
    chk("unhalt data", ifc.tx_ipg_data, 64'hF2);
    tick();
    chk("unhalt drain valid", DW'(ifc.tx_ipg_valid), DW'(0));

`ifdef IVPORT_FIRE_STATS_EN
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("stat clr rreq", DW'(stat_rreq), DW'(0));
    chk("stat clr rresp", DW'(stat_rresp), DW'(0));
    chk("stat clr wreq", DW'(stat_wreq), DW'(0));
    for (int i = 0; i < 3; i++) q_rresp.push_back(64'h7000 + DW'(i));
    for (int i = 0; i < 2; i++) q_rreq.push_back(64'h7100 + DW'(i));
    q_wreq.push_back(64'h7200);
    refresh();
    #1;
    for (int i = 0; i < 7; i++) tick();
    chk("stat rreq", DW'(stat_rreq), DW'(2));
    chk("stat rresp", DW'(stat_rresp), DW'(3));
    chk("stat wreq", DW'(stat_wreq), DW'(1));
    q_rresp.push_back(64'h7300);
    refresh();
    stat_clr = 1'b1;
    #1;
    chk("stat clr pop fire_en", DW'(ifc.fire_en), DW'(1));
    tick();
    stat_clr = 1'b0;
    chk("stat clr2 rreq", DW'(stat_rreq), DW'(0));
    chk("stat clr2 rresp", DW'(stat_rresp), DW'(0));
    chk("stat clr2 wreq", DW'(stat_wreq), DW'(0));
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
